// File: rtl/mem_wb_stage_n.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_n
// N-issue memory-access / write-back stage. One bundle of up to NUM_SLOTS
// results is accepted per cycle (in_valid & ~stall). Loads, stores and
// in-bundle store-to-load forwarding resolve in the accept cycle, and all
// write-back outputs are registered, so the latency is exactly one cycle.
//
// Ports (slot i uses [32*i +: 32], [5*i +: 5], [2*i +: 2] and bit i):
//   clk          clock
//   reset        asynchronous active-low reset (memory is not cleared)
//   in_valid     bundle present
//   stall        downstream hold: bundle ignored, outputs frozen
//   alu_res      per-slot byte address or ALU result
//   wdata        per-slot right-aligned store data
//   mem_read     per-slot load
//   mem_write    per-slot store
//   mem_size     00 byte, 01 half, 10/11 word
//   mem_unsigned per-slot zero-extend (1) / sign-extend (0)
//   reg_write    per-slot register write request
//   rd           per-slot destination index
//   wb_valid     registered bundle valid
//   wb_data      registered write-back data
//   wb_rd        registered destination index
//   wb_en        registered register-file write enable
//   misalign_err registered misaligned-access flag
// ---------------------------------------------------------------------------
module mem_wb_stage_n #(
    parameter int NUM_SLOTS = 2,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic [32*NUM_SLOTS-1:0] alu_res,
    input  logic [32*NUM_SLOTS-1:0] wdata,
    input  logic [NUM_SLOTS-1:0]   mem_read,
    input  logic [NUM_SLOTS-1:0]   mem_write,
    input  logic [2*NUM_SLOTS-1:0] mem_size,
    input  logic [NUM_SLOTS-1:0]   mem_unsigned,
    input  logic [NUM_SLOTS-1:0]   reg_write,
    input  logic [5*NUM_SLOTS-1:0] rd,
    output logic                   wb_valid,
    output logic [32*NUM_SLOTS-1:0] wb_data,
    output logic [5*NUM_SLOTS-1:0] wb_rd,
    output logic [NUM_SLOTS-1:0]   wb_en,
    output logic [NUM_SLOTS-1:0]   misalign_err
);

    logic [31:0] r_mem [DEPTH];

    logic [NUM_SLOTS-1:0][ADDR_W-1:0] w_idx;
    logic [NUM_SLOTS-1:0][1:0]        w_lane;
    logic [NUM_SLOTS-1:0][3:0]        w_bmask;
    logic [NUM_SLOTS-1:0][31:0]       w_sdata;
    logic [NUM_SLOTS-1:0]             w_mis;
    logic [NUM_SLOTS-1:0]             w_st;
    logic [NUM_SLOTS-1:0][31:0]       w_word;
    logic [NUM_SLOTS-1:0][31:0]       w_ld;
    logic [32*NUM_SLOTS-1:0]          w_res;
    logic [NUM_SLOTS-1:0]             w_en;
    logic [NUM_SLOTS-1:0]             w_err;
    logic                             w_accept;

    assign w_accept = in_valid & ~stall;

    // Per-slot address decode: word index, lane mask and lane-replicated
    // store data so that the mask alone selects the written bytes.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            w_idx[i]  = alu_res[32*i+2 +: ADDR_W];
            w_lane[i] = alu_res[32*i +: 2];
            case (mem_size[2*i +: 2])
                2'b00: begin
                    w_mis[i]   = 1'b0;
                    w_bmask[i] = 4'b0001 << w_lane[i];
                    w_sdata[i] = {4{wdata[32*i +: 8]}};
                end
                2'b01: begin
                    w_mis[i]   = w_lane[i][0];
                    w_bmask[i] = w_lane[i][1] ? 4'b1100 : 4'b0011;
                    w_sdata[i] = {2{wdata[32*i +: 16]}};
                end
                default: begin
                    w_mis[i]   = |w_lane[i];
                    w_bmask[i] = 4'b1111;
                    w_sdata[i] = wdata[32*i +: 32];
                end
            endcase
            w_st[i] = mem_write[i] & ~w_mis[i];
        end
    end

    // Loads: pre-bundle memory word merged with older in-bundle stores.
    // Scanning older slots in ascending order lets the youngest older store
    // overwrite earlier ones on shared lanes.
    always_comb begin
        w_res = '0;
        for (int unsigned j = 0; j < NUM_SLOTS; j++) begin
            w_word[j] = r_mem[w_idx[j]];
            for (int unsigned i = 0; i < j; i++) begin
                if (w_st[i] && (w_idx[i] == w_idx[j])) begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (w_bmask[i][b]) begin
                            w_word[j][8*b +: 8] = w_sdata[i][8*b +: 8];
                        end
                    end
                end
            end

            case (mem_size[2*j +: 2])
                2'b00: begin
                    w_ld[j][7:0]  = w_word[j][{w_lane[j], 3'b000} +: 8];
                    w_ld[j][31:8] = {24{~mem_unsigned[j] & w_ld[j][7]}};
                end
                2'b01: begin
                    w_ld[j][15:0]  = w_word[j][{w_lane[j][1], 4'b0000} +: 16];
                    w_ld[j][31:16] = {16{~mem_unsigned[j] & w_ld[j][15]}};
                end
                default: w_ld[j] = w_word[j];
            endcase
            if (w_mis[j]) begin
                w_ld[j] = '0;
            end

            w_res[32*j +: 32] = mem_read[j] ? w_ld[j] : alu_res[32*j +: 32];
            w_en[j]  = in_valid & reg_write[j] & (rd[5*j +: 5] != 5'd0)
                       & ~(mem_read[j] & w_mis[j]);
            w_err[j] = in_valid & (mem_read[j] | mem_write[j]) & w_mis[j];
        end
    end

    // Data memory: no reset; slots written in ascending order so the highest
    // slot's lane wins on overlap.
    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (w_st[i] && w_bmask[i][b]) begin
                        r_mem[w_idx[i]][8*b +: 8] <= w_sdata[i][8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_en        <= '0;
            misalign_err <= '0;
        end else if (!stall) begin
            wb_valid     <= in_valid;
            wb_data      <= w_res;
            wb_rd        <= rd;
            wb_en        <= w_en;
            misalign_err <= w_err;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage_n.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage_n
// Directed cases plus randomized bundles, checked against a byte-addressed
// reference model of the stage's load/store rules.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage_n;

    localparam int NS = 3;
    localparam int DP = 64;
    localparam int NB = DP * 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              stall;
    logic [32*NS-1:0]  alu_res;
    logic [32*NS-1:0]  wdata;
    logic [NS-1:0]     mem_read;
    logic [NS-1:0]     mem_write;
    logic [2*NS-1:0]   mem_size;
    logic [NS-1:0]     mem_unsigned;
    logic [NS-1:0]     reg_write;
    logic [5*NS-1:0]   rd;
    logic              wb_valid;
    logic [32*NS-1:0]  wb_data;
    logic [5*NS-1:0]   wb_rd;
    logic [NS-1:0]     wb_en;
    logic [NS-1:0]     misalign_err;

    mem_wb_stage_n #(.NUM_SLOTS(NS), .DEPTH(DP)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .stall        (stall),
        .alu_res      (alu_res),
        .wdata        (wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .reg_write    (reg_write),
        .rd           (rd),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_en        (wb_en),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0]  mbytes [NB];
    logic        exp_valid;
    logic [31:0] exp_data [NS];
    logic [4:0]  exp_rd [NS];
    logic [NS-1:0] exp_en;
    logic [NS-1:0] exp_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit slot_mis(input int i);
        logic [31:0] a;
        a = alu_res[32*i +: 32];
        return (a % nbytes(mem_size[2*i +: 2])) != 0;
    endfunction

    task automatic clear_bundle();
        in_valid     = 1'b1;
        stall        = 1'b0;
        alu_res      = '0;
        wdata        = '0;
        mem_read     = '0;
        mem_write    = '0;
        mem_size     = '0;
        mem_unsigned = '0;
        reg_write    = '0;
        rd           = '0;
    endtask

    task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] d,
                            input logic r, input logic w, input logic [1:0] sz,
                            input logic u, input logic rw, input logic [4:0] rdi);
        alu_res[32*s +: 32] = a;
        wdata[32*s +: 32]   = d;
        mem_read[s]         = r;
        mem_write[s]        = w;
        mem_size[2*s +: 2]  = sz;
        mem_unsigned[s]     = u;
        reg_write[s]        = rw;
        rd[5*s +: 5]        = rdi;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 32'(wb_valid), 32'(exp_valid));
        chk({tag, "_en"}, 32'(wb_en), 32'(exp_en));
        chk({tag, "_mis"}, 32'(misalign_err), 32'(exp_mis));
        if (exp_valid) begin
            for (int s = 0; s < NS; s++) begin
                chk($sformatf("%s_data%0d", tag, s), wb_data[32*s +: 32], exp_data[s]);
                chk($sformatf("%s_rd%0d", tag, s), 32'(wb_rd[5*s +: 5]), 32'(exp_rd[s]));
            end
        end
    endtask

    // Model one clock: evaluate the presented bundle against the byte-level
    // rules, update the model memory, then compare after the edge.
    task automatic step(input string tag);
        logic [31:0] a, ai, v;
        int unsigned n, ni, ba;
        logic        mis;
        logic [7:0]  b;
        if (!stall && reset) begin
            for (int j = 0; j < NS; j++) begin
                a   = alu_res[32*j +: 32];
                n   = nbytes(mem_size[2*j +: 2]);
                mis = slot_mis(j);
                if (mem_read[j]) begin
                    v = 32'd0;
                    if (!mis) begin
                        for (int unsigned k = 0; k < n; k++) begin
                            ba = (a + k) % NB;
                            b  = mbytes[ba];
                            for (int i = 0; i < j; i++) begin
                                if (mem_write[i] && !slot_mis(i)) begin
                                    ai = alu_res[32*i +: 32];
                                    ni = nbytes(mem_size[2*i +: 2]);
                                    for (int unsigned k2 = 0; k2 < ni; k2++) begin
                                        if (((ai + k2) % NB) == ba) b = wdata[32*i + 8*k2 +: 8];
                                    end
                                end
                            end
                            v = v | (32'(b) << (8 * k));
                        end
                        if (!mem_unsigned[j] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                    end
                end else begin
                    v = a;
                end
                exp_data[j] = v;
                exp_rd[j]   = rd[5*j +: 5];
                exp_en[j]   = in_valid & reg_write[j] & (rd[5*j +: 5] != 5'd0) & ~(mem_read[j] & mis);
                exp_mis[j]  = in_valid & (mem_read[j] | mem_write[j]) & mis;
            end
            exp_valid = in_valid;
            if (in_valid) begin
                for (int i = 0; i < NS; i++) begin
                    if (mem_write[i] && !slot_mis(i)) begin
                        ai = alu_res[32*i +: 32];
                        ni = nbytes(mem_size[2*i +: 2]);
                        for (int unsigned k = 0; k < ni; k++) begin
                            mbytes[(ai + k) % NB] = wdata[32*i + 8*k +: 8];
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_en    = '0;
        exp_mis   = '0;
        for (int s = 0; s < NS; s++) begin
            exp_data[s] = '0;
            exp_rd[s]   = '0;
        end
    endtask

    initial begin
        logic [31:0] r32;
        clear_bundle();
        in_valid = 1'b0;
        reset    = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        #2;
        check_outputs("reset");
        for (int s = 0; s < NS; s++) chk($sformatf("reset_data%0d", s), wb_data[32*s +: 32], 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Fill memory so every load has defined data.
        for (int w = 0; w < DP; w += NS) begin
            clear_bundle();
            for (int s = 0; s < NS; s++) begin
                if (w + s < DP) set_slot(s, 32'((w + s) * 4), $urandom(), 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
            end
            step("init");
        end

        // Store then load in the following bundle.
        clear_bundle();
        set_slot(0, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
        step("sw");
        clear_bundle();
        set_slot(1, 32'h40, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd5);
        step("lw");
        chk("lw_deadbeef", wb_data[63:32], 32'hDEAD_BEEF);
        chk("lw_en1", 32'(wb_en[1]), 32'd1);
        chk("lw_rd1", 32'(wb_rd[9:5]), 32'd5);

        // Sub-word extraction and extension.
        clear_bundle();
        set_slot(0, 32'h40, 32'h0000_80FF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
        step("sw80ff");
        clear_bundle();
        set_slot(0, 32'h40, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd1);
        set_slot(1, 32'h41, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 5'd2);
        set_slot(2, 32'h40, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd3);
        step("ext");
        chk("lb_signed", wb_data[31:0], 32'hFFFF_FFFF);
        chk("lbu", wb_data[63:32], 32'h0000_0080);
        chk("lh_signed", wb_data[95:64], 32'hFFFF_80FF);
        clear_bundle();
        set_slot(0, 32'h40, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd4);
        step("lhu");
        chk("lhu", wb_data[31:0], 32'h0000_80FF);

        // In-bundle forwarding, older store visible, younger not.
        clear_bundle();
        set_slot(0, 32'h40, 32'h1122_3344, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
        step("sw1122");
        clear_bundle();
        set_slot(0, 32'h41, 32'h0000_00AA, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
        set_slot(1, 32'h40, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd6);
        step("fwd");
        chk("fwd_older", wb_data[63:32], 32'h1122_AA44);
        clear_bundle();
        set_slot(0, 32'h40, 32'h1122_3344, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
        step("sw1122b");
        clear_bundle();
        set_slot(0, 32'h40, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd6);
        set_slot(1, 32'h41, 32'h0000_00AA, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
        step("nofwd");
        chk("nofwd_younger", wb_data[31:0], 32'h1122_3344);
        clear_bundle();
        set_slot(0, 32'h40, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd6);
        step("after_sb");
        chk("after_sb", wb_data[31:0], 32'h1122_AA44);

        // Same-word stores: highest slot wins; misaligned accesses suppressed.
        clear_bundle();
        set_slot(0, 32'h80, 32'd1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
        set_slot(1, 32'h80, 32'd2, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
        step("sw2");
        clear_bundle();
        set_slot(0, 32'h43, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 5'd7);
        set_slot(1, 32'h83, 32'hFFFF, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
        step("misal");
        chk("misal_err", 32'(misalign_err[1:0]), 32'd3);
        chk("misal_en0", 32'(wb_en[0]), 32'd0);
        clear_bundle();
        set_slot(0, 32'h80, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd8);
        step("lw80");
        chk("slot_hi_wins", wb_data[31:0], 32'd2);

        // Stall: store presented for three stalled cycles must not land.
        clear_bundle();
        set_slot(0, 32'h90, 32'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
        step("sw90z");
        clear_bundle();
        set_slot(0, 32'h90, 32'h5566_7788, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd9);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) step("stall");
        clear_bundle();
        set_slot(0, 32'h90, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd9);
        step("stall_nowr");
        chk("stall_nowrite", wb_data[31:0], 32'd0);
        clear_bundle();
        set_slot(0, 32'h90, 32'h5566_7788, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd9);
        stall = 1'b1;
        step("stall2");
        stall = 1'b0;
        step("release");
        chk("release_valid", 32'(wb_valid), 32'd1);
        clear_bundle();
        set_slot(0, 32'h90, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd9);
        step("lw90");
        chk("release_store", wb_data[31:0], 32'h5566_7788);

        // rd = 0 never enables a write.
        clear_bundle();
        set_slot(0, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd0);
        step("rd0");
        chk("rd0_en", 32'(wb_en[0]), 32'd0);

        // Asynchronous reset mid-stream with a store bundle in flight.
        clear_bundle();
        set_slot(0, 32'hA0, 32'hCAFE_F00D, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 5'd3);
        #1 reset = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        for (int s = 0; s < NS; s++) chk($sformatf("async_rst_data%0d", s), wb_data[32*s +: 32], 32'd0);
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        reset = 1'b1;
        clear_bundle();
        set_slot(0, 32'h40, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd1);
        set_slot(1, 32'hA0, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd2);
        step("persist");
        chk("persist_40", wb_data[31:0], 32'h1122_AA44);

        // Randomized bundles concentrated on a few words to force overlap.
        for (int c = 0; c < 500; c++) begin
            in_valid = ($urandom_range(0, 99) < 85);
            stall    = ($urandom_range(0, 99) < 20);
            for (int s = 0; s < NS; s++) begin
                int unsigned kind;
                kind = $urandom_range(0, 4);
                r32  = $urandom();
                if (kind != 0) r32[7:0] = 8'($urandom_range(0, 15));
                alu_res[32*s +: 32] = r32;
                wdata[32*s +: 32]   = $urandom();
                mem_read[s]         = (kind == 1) || (kind == 3) || (kind == 4);
                mem_write[s]        = (kind == 2) || (kind == 3);
                mem_size[2*s +: 2]  = 2'($urandom_range(0, 3));
                mem_unsigned[s]     = 1'($urandom_range(0, 1));
                reg_write[s]        = ($urandom_range(0, 3) != 0);
                rd[5*s +: 5]        = 5'($urandom_range(0, 31));
            end
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
